// File: rtl/mtm_alu_core_pipe.sv
// mtm_alu_core_pipe: buffered ALU core; define MTM_ALU_MUL_EN to enable opcode 010 = MUL
module mtm_alu_core_pipe #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [2:0]       crc,
    output logic             op_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = WIDTH + 8;
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    logic             legal;
    logic [3:0]       fl;
    logic [EW-1:0]    entry;
    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

`ifdef MTM_ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

    // CRC-3, x^3+x+1, zero seed, shifted MSB-first
    function automatic logic [2:0] crc3(input logic [WIDTH+4:0] d);
        logic [2:0] c;
        logic       fb;
        c = '0;
        for (int i = WIDTH + 4; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    // Combinational ALU: result, carry/borrow and signed overflow per opcode
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        dif   = {1'b0, a} - {1'b0, b};
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        legal = 1'b1;
        case (opcode)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b100: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            3'b101: begin
                res   = dif[WIDTH-1:0];
                carry = dif[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
`ifdef MTM_ALU_MUL_EN
            3'b010: begin
                res   = prod[WIDTH-1:0];
                carry = |prod[2*WIDTH-1:WIDTH];
                ovf   = carry;
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    // Illegal opcodes produce an all-zero response with only op_err set
    assign fl    = legal ? {carry, ovf, res == '0, res[WIDTH-1]} : 4'b0000;
    assign entry = {res, fl, legal ? crc3({res, 1'b0, fl}) : 3'b000, !legal};

    assign in_ready  = rst_n && (count != FULL);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign {result, flags, crc, op_err} = mem[rd_ptr];

    // Result FIFO: storage cleared on reset so the head reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_mtm_alu_core_pipe.sv
// tb_mtm_alu_core_pipe: directed and randomized checks of mtm_alu_core_pipe against a reference model
module tb_mtm_alu_core_pipe;
    localparam int W = 32;
    localparam int D = 2;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  fl;
        logic [2:0]  crc;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [2:0]  crc;
    logic        op_err;
    resp_t       got;
    int          errors = 0;
    int          checks = 0;

    mtm_alu_core_pipe #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .crc(crc), .op_err(op_err)
    );

    assign got = {result, flags, crc, op_err};

    always #5 clk = ~clk;

`ifdef MTM_ALU_MUL_EN
    localparam logic [3:0] MUL_FL  = 4'b1110;
    localparam logic       MUL_ERR = 1'b0;
`else
    localparam logic [3:0] MUL_FL  = 4'b0000;
    localparam logic       MUL_ERR = 1'b1;
`endif

    localparam logic [31:0] DA [8] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h12345678,
                                       32'hF0F0F0F0, 32'h7FFFFFFF, 32'h00010000, 32'h0F0F0000};
    localparam logic [31:0] DB [8] = '{32'h00000001, 32'h00000001, 32'h00000002, 32'h00000000,
                                       32'h0FF00FF0, 32'h00000001, 32'h00010000, 32'h000000F0};
    localparam logic [2:0]  DO [8] = '{3'b100, 3'b101, 3'b101, 3'b111, 3'b000, 3'b100, 3'b010, 3'b001};
    localparam logic [31:0] DR [8] = '{32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                                       32'h00F000F0, 32'h80000000, 32'h00000000, 32'h0F0F00F0};
    localparam logic [3:0]  DF [8] = '{4'b1010, 4'b0100, 4'b1001, 4'b0000, 4'b0000, 4'b0101, MUL_FL, 4'b0000};
    localparam logic        DE [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MUL_ERR, 1'b0};

    // CRC as the remainder of the message times x^3 divided by x^3+x+1
    function automatic logic [2:0] crc_ref(input logic [36:0] m);
        logic [39:0] r;
        r = {m, 3'b000};
        for (int i = 39; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    function automatic resp_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        resp_t       r;
        logic [63:0] wide;
        logic        c;
        logic        v;
        logic        ok;
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        ok = 1'b1;
        if (op == 3'b000) r.res = x & y;
        else if (op == 3'b001) r.res = x | y;
        else if (op == 3'b100) begin
            wide  = 64'(x) + 64'(y);
            r.res = wide[31:0];
            c     = wide > 64'hFFFFFFFF;
            v     = (x[31] == y[31]) && (r.res[31] != x[31]);
        end else if (op == 3'b101) begin
            r.res = x - y;
            c     = x < y;
            v     = (x[31] != y[31]) && (r.res[31] != x[31]);
        end
`ifdef MTM_ALU_MUL_EN
        else if (op == 3'b010) begin
            wide  = 64'(x) * 64'(y);
            r.res = wide[31:0];
            c     = wide > 64'hFFFFFFFF;
            v     = c;
        end
`endif
        else ok = 1'b0;
        if (ok) begin
            r.fl  = {c, v, r.res == 0, r.res[31]};
            r.crc = crc_ref({r.res, 1'b0, r.fl});
        end
        r.err = !ok;
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000 ^ 32'($urandom_range(0, 3));
            3: return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_head: got %h expected 0", got); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
        resp_t e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = DA[i]; b = DB[i]; opcode = DO[i]; in_valid = 1'b1; out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            e = model(DA[i], DB[i], DO[i]);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid: got %b expected 1", i, out_valid); end
            checks++;
            if (got !== e) begin errors++; $display("FAIL dir%0d_model: got %h expected %h", i, got, e); end
            checks++;
            if (result !== DR[i] || flags !== DF[i] || op_err !== DE[i])
                begin errors++; $display("FAIL dir%0d_const: got %h/%b/%b expected %h/%b/%b", i, result, flags, op_err, DR[i], DF[i], DE[i]); end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_pop: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_fill();
        logic [31:0] x [3];
        logic [31:0] y [3];
        resp_t       e [3];
        for (int i = 0; i < 3; i++) begin
            x[i] = $urandom; y[i] = $urandom; e[i] = model(x[i], y[i], 3'b100);
        end
        @(negedge clk);
        a = x[0]; b = y[0]; opcode = 3'b100; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready1: got %b expected 1", in_ready); end
        a = x[1]; b = y[1];
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %b expected 0", in_ready); end
        a = x[2]; b = y[2];
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || got !== e[0])
            begin errors++; $display("FAIL fill_hold: got %b/%b/%h expected 0/1/%h", in_ready, out_valid, got, e[0]); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || got !== e[1])
            begin errors++; $display("FAIL fill_pop1: got %b/%h expected 1/%h", in_ready, got, e[1]); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || got !== e[2])
            begin errors++; $display("FAIL fill_third: got %b/%h expected 1/%h", out_valid, got, e[2]); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = $urandom; b = $urandom; opcode = 3'b001; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        a = $urandom; opcode = 3'b100;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            begin errors++; $display("FAIL mid_full: got %b/%b expected 0/1", in_ready, out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || got !== '0 || in_ready !== 1'b0)
            begin errors++; $display("FAIL mid_reset: got %b/%h/%b expected 0/0/0", out_valid, got, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL mid_release: got %b/%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic run_scoreboard(input string tag, input int cycles, input bit full_rate);
        resp_t q [$];
        bit    push;
        bit    pop;
        for (int n = 0; n < cycles + D + 1; n++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (q.size() != 0))
                begin errors++; $display("FAIL %s_valid@%0d: got %b expected %b", tag, n, out_valid, q.size() != 0); end
            checks++;
            if (in_ready !== (q.size() < D))
                begin errors++; $display("FAIL %s_ready@%0d: got %b expected %b", tag, n, in_ready, q.size() < D); end
            if (q.size() != 0) begin
                checks++;
                if (got !== q[0]) begin errors++; $display("FAIL %s_head@%0d: got %h expected %h", tag, n, got, q[0]); end
            end
            if (n < cycles) begin
                in_valid  = full_rate || ($urandom_range(0, 3) != 0);
                out_ready = full_rate || ($urandom_range(0, 2) != 0);
                a = pick(); b = pick(); opcode = 3'($urandom_range(0, 7));
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            pop  = out_ready && (q.size() != 0);
            push = in_valid && (q.size() < D);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(model(a, b, opcode));
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0;
        test_reset();
        test_directed();
        test_fill();
        test_reset_mid();
        run_scoreboard("random", 400, 1'b0);
        run_scoreboard("back_to_back", 40, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mtm_alu_core_pipe.md
# mtm_alu_core_pipe

Parametrised, buffered ALU core for the serial ALU datapath. It sits between the frame deserializer and the result serializer. It accepts operand pairs and an opcode over a valid/ready handshake and computes result, flags, CRC-3 and operation error. Results are queued in an output FIFO, so the deserializer can keep receiving while the serializer is still shifting out a previous response.

## Interface
- `WIDTH`, 32: operand and result width in bits; must be ≥ 8.
- `FIFO_DEPTH`, 2: number of result entries buffered; must be a power of two, ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: operand pair and opcode present.
- `in_ready` out 1: core can accept an operation.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `opcode` in 3: 000 AND, 001 OR, 100 ADD, 101 SUB; all other codes are illegal.
- `out_valid` out 1: FIFO head holds a response.
- `out_ready` in 1: serializer takes the head entry.
- `result` out WIDTH: result at the FIFO head.
- `flags` out 4: {carry, overflow, zero, negative} at the FIFO head.
- `crc` out 3: CRC-3 of the head entry.
- `op_err` out 1: head entry came from an illegal opcode.

## Operation
- **Accept.** An operation is accepted on an edge where `in_valid && in_ready`. `in_ready = !full`. An accept when the FIFO is full cannot occur.
- **Compute.** The computation is combinational from a, b and opcode. The outcome {result, flags, crc, op_err} is written into the FIFO on the accept edge.
- **AND / OR.** Bitwise. carry = 0, overflow = 0.
- **ADD.** Computed as a (WIDTH+1)-bit sum. carry = bit WIDTH of the sum. overflow is set when a and b have the same sign and the result sign differs.
- **SUB.** result = a − b. carry = borrow, i.e. 1 when a < b unsigned. overflow is set when a and b have different signs and the result sign differs from a.
- **zero / negative.** zero = (result == 0). negative = result[WIDTH−1].
- **CRC.** CRC-3, polynomial x³+x+1, initial value 000. Computed MSB-first over the (WIDTH+5)-bit vector {result, 1'b0, flags}.
- **Illegal opcode.** result = 0, flags = 0000, crc = 000, op_err = 1. The core keeps accepting further operations.
- **FIFO.** Write and read pointers wrap modulo FIFO_DEPTH, plus an occupancy count of 0..FIFO_DEPTH.
  - Pop occurs on `out_valid && out_ready`.
  - Push and pop on the same edge leave the count unchanged. This is legal only when the FIFO is not full; there is no pass-through when full.
  - Pop when empty is ignored.
- **Ordering.** Responses leave in strict acceptance order.
- **Reset.** Asserting `rst_n` low at any time clears the pointers and count and discards buffered entries.
- **Output reset values.** `in_ready` = 0 while `rst_n` is low and 1 after release. `out_valid` = 0. `result` = 0, `flags` = 0, `crc` = 0, `op_err` = 0.

## Timing
- **Latency.** Accept at edge N with the FIFO empty: `out_valid` = 1 and the head fields are valid after edge N. Back-to-back accepts are possible every cycle while not full.
- **Head stability.** Head fields are stable while `out_valid && !out_ready`.
- **Fill.** After FIFO_DEPTH accepts with no pop, `in_ready` drops after the last accept edge. It rises after the next pop edge.
- **Throughput.** With `out_ready` held at 1, throughput is one operation per cycle.
- **Outputs.** All outputs are registered or driven directly from FIFO storage. There is no combinational path from `in_valid` to `out_valid`.

## Configuration
- `MTM_ALU_MUL_EN` defined:
  - opcode 010 = MUL; result = low WIDTH bits of the unsigned a×b.
  - carry = overflow = (high WIDTH bits ≠ 0).
  - zero and negative follow the usual rule.
  - The multiply is still single-cycle combinational.
- `MTM_ALU_MUL_EN` undefined: opcode 010 is illegal and behaves as an illegal opcode (op_err = 1).

## Test plan
- **ADD with carry.** WIDTH=32, ADD a=0xFFFFFFFF, b=0x00000001 → result 0x00000000, flags 1010, op_err 0. crc equals the model CRC of {0x00000000, 0, 1010}.
- **SUB with overflow.** SUB a=0x80000000, b=0x00000001 → result 0x7FFFFFFF, flags 0100. SUB a=0x00000001, b=0x00000002 → result 0xFFFFFFFF, flags 1001.
- **Illegal opcode.** Opcode 111 with a=0x12345678 → result 0, flags 0000, crc 000, op_err 1. A following AND of 0xF0F0F0F0 and 0x0FF00FF0 → result 0x00F000F0, flags 0000.
- **Fill and drain.** FIFO_DEPTH=2, `out_ready` = 0, three ADDs offered back-to-back → two accepted and `in_ready` = 0. Raise `out_ready` → responses appear in order and the third is accepted after the first pop.
- **Reset mid-operation.** Assert `rst_n` low with two entries buffered → `out_valid` = 0 and all outputs 0 immediately. After release `in_ready` = 1 and the FIFO is empty.
- **MUL, both configurations.** With `MTM_ALU_MUL_EN`: MUL a=0x00010000, b=0x00010000 → result 0, flags 1110. Without the macro: same stimulus → op_err 1.
